// File: rtl/output_ram_writer.sv
// Write side of the frame-buffer path: takes a raster-order pixel stream over
// a valid/ready handshake and writes it into the output frame RAM. The
// column/row position is tracked here. The address map matches the
// coordinate-addressed input ROM reader, so a frame written here reads back
// at the same (col,row).
module output_ram_writer #(
  parameter int WIDTH_BITS  = 8,
  parameter int HEIGHT_BITS = 8,
  parameter int ADDR_WIDTH  = 16
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   iStart,
  input  logic                   iValid,
  input  logic [7:0]             iData,
  output logic                   oReady,
  output logic                   oWrEn,
  output logic [ADDR_WIDTH-1:0]  oWrAddress,
  output logic [7:0]             oWrData,
  output logic                   oBusy,
  output logic                   oDone,
  output logic [WIDTH_BITS-1:0]  oCol,
  output logic [HEIGHT_BITS-1:0] oRow
);

  localparam int FULL_BITS = WIDTH_BITS + HEIGHT_BITS;
  localparam logic [WIDTH_BITS-1:0]  COL_MAX = '1;
  localparam logic [HEIGHT_BITS-1:0] ROW_MAX = '1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [WIDTH_BITS-1:0]   col_q, col_d;
  logic [HEIGHT_BITS-1:0]  row_q, row_d;
  logic                    wrEn_q, wrEn_d;
  logic [ADDR_WIDTH-1:0]   wrAddr_q, wrAddr_d;
  logic [7:0]              wrData_q, wrData_d;
  logic                    accept;
  logic [FULL_BITS-1:0]    fullAddr;

  // Row-major address: concatenating row above col is (row << WIDTH_BITS) + col
  assign fullAddr = {row_q, col_q};

  // Handshake and status flags depend on state only, so oReady never loops back to iValid
  assign accept = (state_q == WRITE) && iValid;
  assign oReady = (state_q == WRITE);
  assign oBusy  = (state_q != IDLE);
  // The FLUSH cycle is the one where the last pixel's write is on the port
  assign oDone  = (state_q == FLUSH);

  assign oWrEn      = wrEn_q;
  assign oWrAddress = wrAddr_q;
  assign oWrData    = wrData_q;
  assign oCol       = col_q;
  assign oRow       = row_q;

  // Next-state logic: frame sequencing, raster counters and the registered write request
  always_comb begin
    state_d  = state_q;
    col_d    = col_q;
    row_d    = row_q;
    wrEn_d   = 1'b0;
    wrAddr_d = wrAddr_q;
    wrData_d = wrData_q;
    case (state_q)
      IDLE: begin
        if (iStart) begin
          state_d = WRITE;
          col_d   = '0;
          row_d   = '0;
        end
      end
      WRITE: begin
        if (accept) begin
          wrEn_d   = 1'b1;
          wrAddr_d = ADDR_WIDTH'(fullAddr);
          wrData_d = iData;
          col_d    = col_q + WIDTH_BITS'(1);
          if (col_q == COL_MAX) begin
            row_d = row_q + HEIGHT_BITS'(1);
            if (row_q == ROW_MAX) begin
              state_d = FLUSH;
            end
          end
        end
      end
      FLUSH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset abandons any frame immediately
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      col_q    <= '0;
      row_q    <= '0;
      wrEn_q   <= 1'b0;
      wrAddr_q <= '0;
      wrData_q <= '0;
    end else begin
      state_q  <= state_d;
      col_q    <= col_d;
      row_q    <= row_d;
      wrEn_q   <= wrEn_d;
      wrAddr_q <= wrAddr_d;
      wrData_q <= wrData_d;
    end
  end

endmodule
